// File: rtl/prover_compute_v_endist_if.sv
// Sequencer/consumer-facing bundle of the compute_v enable distributor.
// Array index order is [consumer][lane] for rdy_in/en_out, matching the collect side.
interface prover_compute_v_endist_if #(
  parameter int unsigned ninputs   = 8,
  parameter int unsigned nParallel = 4
);
  logic                 en_master;
  logic [nParallel-1:0] en_in;
  logic [nParallel-1:0] rdy_in [ninputs-1:0];
  logic [nParallel-1:0] en_out [ninputs-1:0];
  logic [nParallel-1:0] full;
  logic [nParallel-1:0] idle;
  logic                 clr_overflow;
  logic                 overflow;

  modport master (
    output en_master, en_in, rdy_in, clr_overflow,
    input  en_out, full, idle, overflow
  );

  modport slave (
    input  en_master, en_in, rdy_in, clr_overflow,
    output en_out, full, idle, overflow
  );
endinterface

// File: rtl/prover_compute_v_endist.sv
// Enable-pulse distributor: each lane fans a sequencer pulse out to every consumer,
// with per-(lane, consumer) credit counters absorbing up to `depth` pulses of lag.
module prover_compute_v_endist #(
  parameter int unsigned ninputs   = 8,
  parameter int unsigned nParallel = 4,
  parameter int unsigned depth     = 2
) (
  input logic                         clk,
  input logic                         rstb,
  prover_compute_v_endist_if.slave    bus
);
  localparam int unsigned   cw      = $clog2(depth + 1);
  localparam logic [cw-1:0] cnt_max = cw'(depth);
  localparam logic [cw-1:0] cnt_one = cw'(1);

  logic [cw-1:0]        cnt_q [nParallel][ninputs];
  logic [cw-1:0]        cnt_d [nParallel][ninputs];
  logic                 overflow_q;
  logic                 overflow_d;
  logic [nParallel-1:0] full;
  logic [nParallel-1:0] idle;
  logic [nParallel-1:0] accept;
  logic [nParallel-1:0] drop;
  logic [nParallel-1:0] en_out [ninputs];

  // Status and delivery come straight from the registers; en_in never reaches en_out.
  always_comb begin
    full = '0;
    idle = '1;
    for (int unsigned i = 0; i < ninputs; i++) en_out[i] = '0;
    for (int unsigned p = 0; p < nParallel; p++) begin
      for (int unsigned i = 0; i < ninputs; i++) begin
        if (cnt_q[p][i] == cnt_max) full[p] = 1'b1;
        if (cnt_q[p][i] != '0)      idle[p] = 1'b0;
        en_out[i][p] = (cnt_q[p][i] != '0) & bus.rdy_in[i][p] & bus.en_master;
      end
    end
  end

  // A pulse arriving at a full lane is dropped for all consumers; a same-cycle drain cannot rescue it.
  always_comb begin
    accept = bus.en_in & ~full;
    drop   = bus.en_in & full;
    for (int unsigned p = 0; p < nParallel; p++) begin
      for (int unsigned i = 0; i < ninputs; i++) begin
        cnt_d[p][i] = cnt_q[p][i];
        if (accept[p] && !en_out[i][p])
          cnt_d[p][i] = cnt_q[p][i] + cnt_one;
        else if (!accept[p] && en_out[i][p])
          cnt_d[p][i] = cnt_q[p][i] - cnt_one;
      end
    end
    overflow_d = overflow_q;
    if (|drop)
      overflow_d = 1'b1;
    else if (bus.clr_overflow)
      overflow_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      for (int unsigned p = 0; p < nParallel; p++)
        for (int unsigned i = 0; i < ninputs; i++)
          cnt_q[p][i] <= '0;
      overflow_q <= 1'b0;
    end else begin
      for (int unsigned p = 0; p < nParallel; p++)
        for (int unsigned i = 0; i < ninputs; i++)
          cnt_q[p][i] <= cnt_d[p][i];
      overflow_q <= overflow_d;
    end
  end

  assign bus.en_out   = en_out;
  assign bus.full     = full;
  assign bus.idle     = idle;
  assign bus.overflow = overflow_q;
endmodule

// File: tb/tb_prover_compute_v_endist.sv
// Scoreboarded bench for prover_compute_v_endist: expected pulses are queued per
// (lane, consumer) when stimulus is driven and retired as en_out pulses are seen.
module tb_prover_compute_v_endist;
  localparam int unsigned NI    = 8;
  localparam int unsigned NP    = 4;
  localparam int unsigned DEPTH = 2;

  logic clk  = 1'b0;
  logic rstb = 1'b1;
  always #5 clk = ~clk;

  prover_compute_v_endist_if #(.ninputs(NI), .nParallel(NP)) bus ();

  prover_compute_v_endist #(.ninputs(NI), .nParallel(NP), .depth(DEPTH)) dut (
    .clk  (clk),
    .rstb (rstb),
    .bus  (bus)
  );

  typedef struct {
    int unsigned lane;
    int unsigned cons;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic push_lane(input int unsigned p, input int unsigned n);
    exp_t e;
    for (int unsigned k = 0; k < n; k++)
      for (int unsigned i = 0; i < NI; i++) begin
        e.lane = p;
        e.cons = i;
        exp_q.push_back(e);
      end
  endtask

  // Retire observed pulses at the falling edge, then move to just after the next rising edge.
  task automatic tick();
    int idx;
    @(negedge clk);
    for (int unsigned i = 0; i < NI; i++)
      for (int unsigned p = 0; p < NP; p++)
        if (bus.en_out[i][p] === 1'b1) begin
          idx = -1;
          foreach (exp_q[k])
            if (idx < 0 && exp_q[k].lane == p && exp_q[k].cons == i) idx = k;
          checks++;
          if (idx < 0) begin
            errors++;
            $display("FAIL sb_unexpected lane %0d cons %0d: got en_out=1, expected 0 (no pulse pending)", p, i);
          end else
            exp_q.delete(idx);
        end
    @(posedge clk);
    #1;
  endtask

  task automatic check_drained(input string name);
    checks++;
    if (exp_q.size() !== 0) begin
      errors++;
      $display("FAIL %s_missing: got %0d undelivered pulses, expected 0", name, exp_q.size());
    end
    exp_q.delete();
  endtask

  task automatic test_reset();
    bus.en_master    = 1'b0;
    bus.en_in        = '0;
    bus.clr_overflow = 1'b0;
    for (int unsigned i = 0; i < NI; i++) bus.rdy_in[i] = '0;
    #1 rstb = 1'b0;
    #1;
    checks++; if (bus.idle !== 4'b1111) begin errors++; $display("FAIL rst_idle: got %b, expected 1111", bus.idle); end
    checks++; if (bus.full !== 4'b0000) begin errors++; $display("FAIL rst_full: got %b, expected 0000", bus.full); end
    checks++; if (bus.overflow !== 1'b0) begin errors++; $display("FAIL rst_overflow: got %b, expected 0", bus.overflow); end
    for (int unsigned i = 0; i < NI; i++) begin
      checks++; if (bus.en_out[i] !== 4'b0000) begin errors++; $display("FAIL rst_en_out cons %0d: got %b, expected 0000", i, bus.en_out[i]); end
    end
    repeat (2) @(posedge clk);
    #1 rstb = 1'b1;
    tick();
    checks++; if (bus.idle !== 4'b1111) begin errors++; $display("FAIL post_rst_idle: got %b, expected 1111", bus.idle); end
  endtask

  task automatic test_single_pulse();
    bus.en_master = 1'b1;
    for (int unsigned i = 0; i < NI; i++) bus.rdy_in[i] = '1;
    push_lane(0, 1);
    bus.en_in = 4'b0001;
    tick();
    bus.en_in = '0;
    for (int unsigned i = 0; i < NI; i++) begin
      checks++; if (bus.en_out[i] !== 4'b0001) begin errors++; $display("FAIL single_pulse cons %0d: got %b, expected 0001", i, bus.en_out[i]); end
    end
    checks++; if (bus.idle[0] !== 1'b0) begin errors++; $display("FAIL single_busy: got idle0=%b, expected 0", bus.idle[0]); end
    tick();
    for (int unsigned i = 0; i < NI; i++) begin
      checks++; if (bus.en_out[i] !== 4'b0000) begin errors++; $display("FAIL single_after cons %0d: got %b, expected 0000", i, bus.en_out[i]); end
    end
    checks++; if (bus.idle !== 4'b1111) begin errors++; $display("FAIL single_idle: got %b, expected 1111", bus.idle); end
    tick();
    check_drained("single");
  endtask

  task automatic test_overflow_depth();
    for (int unsigned i = 0; i < NI; i++) bus.rdy_in[i] = '1;
    bus.rdy_in[3][1] = 1'b0;
    push_lane(1, 2);
    bus.en_in = 4'b0010;
    tick();
    checks++; if (bus.full[1] !== 1'b0) begin errors++; $display("FAIL ovf_full_first: got %b, expected 0", bus.full[1]); end
    tick();
    checks++; if (bus.full[1] !== 1'b1) begin errors++; $display("FAIL ovf_full_second: got %b, expected 1", bus.full[1]); end
    checks++; if (bus.overflow !== 1'b0) begin errors++; $display("FAIL ovf_early: got %b, expected 0", bus.overflow); end
    tick();
    bus.en_in = '0;
    checks++; if (bus.overflow !== 1'b1) begin errors++; $display("FAIL ovf_set: got %b, expected 1", bus.overflow); end
    checks++; if (bus.full[1] !== 1'b1) begin errors++; $display("FAIL ovf_full_held: got %b, expected 1", bus.full[1]); end
    repeat (2) tick();
    checks++; if (exp_q.size() !== 2) begin errors++; $display("FAIL ovf_pending_c3: got %0d pending, expected 2", exp_q.size()); end
    bus.rdy_in[3][1] = 1'b1;
    repeat (3) tick();
    checks++; if (bus.idle[1] !== 1'b1) begin errors++; $display("FAIL ovf_idle: got %b, expected 1", bus.idle[1]); end
    check_drained("ovf");
    bus.clr_overflow = 1'b1;
    tick();
    bus.clr_overflow = 1'b0;
    checks++; if (bus.overflow !== 1'b0) begin errors++; $display("FAIL ovf_clear: got %b, expected 0", bus.overflow); end
  endtask

  task automatic test_simultaneous();
    for (int unsigned i = 0; i < NI; i++) bus.rdy_in[i][2] = 1'b0;
    push_lane(2, 2);
    bus.en_in = 4'b0100;
    tick();
    bus.en_in = '0;
    checks++; if (bus.idle[2] !== 1'b0) begin errors++; $display("FAIL simul_busy: got %b, expected 0", bus.idle[2]); end
    for (int unsigned i = 0; i < NI; i++) bus.rdy_in[i][2] = 1'b1;
    bus.en_in = 4'b0100;
    tick();
    bus.en_in = '0;
    checks++; if (bus.full[2] !== 1'b0) begin errors++; $display("FAIL simul_full: got %b, expected 0", bus.full[2]); end
    checks++; if (bus.overflow !== 1'b0) begin errors++; $display("FAIL simul_overflow: got %b, expected 0", bus.overflow); end
    for (int unsigned i = 0; i < NI; i++) begin
      checks++; if (bus.en_out[i][2] !== 1'b1) begin errors++; $display("FAIL simul_hold cons %0d: got %b, expected 1", i, bus.en_out[i][2]); end
    end
    tick();
    checks++; if (bus.idle[2] !== 1'b1) begin errors++; $display("FAIL simul_idle: got %b, expected 1", bus.idle[2]); end
    tick();
    check_drained("simul");
  endtask

  task automatic test_master_gate();
    for (int unsigned i = 0; i < NI; i++) bus.rdy_in[i] = '1;
    bus.en_master = 1'b0;
    push_lane(0, 2);
    bus.en_in = 4'b0001;
    tick();
    checks++; if (bus.full[0] !== 1'b0) begin errors++; $display("FAIL gate_full_first: got %b, expected 0", bus.full[0]); end
    tick();
    bus.en_in = '0;
    checks++; if (bus.full[0] !== 1'b1) begin errors++; $display("FAIL gate_full: got %b, expected 1", bus.full[0]); end
    tick();
    for (int unsigned i = 0; i < NI; i++) begin
      checks++; if (bus.en_out[i][0] !== 1'b0) begin errors++; $display("FAIL gate_frozen cons %0d: got %b, expected 0", i, bus.en_out[i][0]); end
    end
    bus.en_master = 1'b1;
    #1;
    for (int unsigned i = 0; i < NI; i++) begin
      checks++; if (bus.en_out[i][0] !== 1'b1) begin errors++; $display("FAIL gate_first cons %0d: got %b, expected 1", i, bus.en_out[i][0]); end
    end
    tick();
    for (int unsigned i = 0; i < NI; i++) begin
      checks++; if (bus.en_out[i][0] !== 1'b1) begin errors++; $display("FAIL gate_second cons %0d: got %b, expected 1", i, bus.en_out[i][0]); end
    end
    tick();
    for (int unsigned i = 0; i < NI; i++) begin
      checks++; if (bus.en_out[i][0] !== 1'b0) begin errors++; $display("FAIL gate_done cons %0d: got %b, expected 0", i, bus.en_out[i][0]); end
    end
    checks++; if (bus.idle[0] !== 1'b1) begin errors++; $display("FAIL gate_idle: got %b, expected 1", bus.idle[0]); end
    check_drained("gate");
  endtask

  task automatic test_clr_overflow();
    for (int unsigned i = 0; i < NI; i++) bus.rdy_in[i][2] = 1'b0;
    push_lane(2, 2);
    bus.en_in = 4'b0100;
    repeat (2) tick();
    checks++; if (bus.full[2] !== 1'b1) begin errors++; $display("FAIL clr_full: got %b, expected 1", bus.full[2]); end
    checks++; if (bus.overflow !== 1'b0) begin errors++; $display("FAIL clr_pre: got %b, expected 0", bus.overflow); end
    tick();
    checks++; if (bus.overflow !== 1'b1) begin errors++; $display("FAIL clr_set: got %b, expected 1", bus.overflow); end
    bus.clr_overflow = 1'b1;
    tick();
    checks++; if (bus.overflow !== 1'b1) begin errors++; $display("FAIL clr_set_wins: got %b, expected 1", bus.overflow); end
    bus.en_in = '0;
    tick();
    bus.clr_overflow = 1'b0;
    checks++; if (bus.overflow !== 1'b0) begin errors++; $display("FAIL clr_alone: got %b, expected 0", bus.overflow); end
    for (int unsigned i = 0; i < NI; i++) bus.rdy_in[i][2] = 1'b1;
    repeat (3) tick();
    checks++; if (bus.idle[2] !== 1'b1) begin errors++; $display("FAIL clr_idle: got %b, expected 1", bus.idle[2]); end
    check_drained("clr");
  endtask

  // The two lane-3 pulses are never pushed: reset must discard them before any delivery.
  task automatic test_reset_mid();
    for (int unsigned i = 0; i < NI; i++) bus.rdy_in[i][3] = 1'b0;
    bus.en_in = 4'b1000;
    repeat (2) tick();
    bus.en_in = '0;
    checks++; if (bus.full[3] !== 1'b1) begin errors++; $display("FAIL rmid_full: got %b, expected 1", bus.full[3]); end
    for (int unsigned i = 0; i < NI; i++) bus.rdy_in[i][3] = 1'b1;
    #1;
    for (int unsigned i = 0; i < NI; i++) begin
      checks++; if (bus.en_out[i][3] !== 1'b1) begin errors++; $display("FAIL rmid_draining cons %0d: got %b, expected 1", i, bus.en_out[i][3]); end
    end
    rstb = 1'b0;
    #1;
    for (int unsigned i = 0; i < NI; i++) begin
      checks++; if (bus.en_out[i] !== 4'b0000) begin errors++; $display("FAIL rmid_en_out cons %0d: got %b, expected 0000", i, bus.en_out[i]); end
    end
    checks++; if (bus.idle !== 4'b1111) begin errors++; $display("FAIL rmid_idle: got %b, expected 1111", bus.idle); end
    repeat (2) @(posedge clk);
    #1 rstb = 1'b1;
    repeat (4) tick();
    checks++; if (bus.idle[3] !== 1'b1) begin errors++; $display("FAIL rmid_idle_after: got %b, expected 1", bus.idle[3]); end
    check_drained("rmid");
  endtask

  initial begin
    test_reset();
    test_single_pulse();
    test_overflow_depth();
    test_simultaneous();
    test_master_gate();
    test_clr_overflow();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout at %0t, expected completion", $time);
    $fatal(1);
  end
endmodule

// File: doc/prover_compute_v_endist.md
# prover_compute_v_endist

Enable-pulse distributor for the prover compute_v datapath: the sending end of the per-lane enable collection. Each of `nParallel` lanes accepts a single enable pulse from the sequencer and fans it out as one pulse to each of `ninputs` consumers, each paced by its own ready signal. Per-(lane, consumer) credit counters let consumers fall up to `depth` pulses behind. Per-lane full/idle status back-pressures the sequencer.

## Interface
- `ninputs`, 8, number of consumers per lane
- `nParallel`, 4, number of parallel lanes
- `depth`, 2, maximum outstanding pulses per (lane, consumer); must be ≥1; counter width `cw = $clog2(depth+1)`

Ports:
- `clk`  in  1  single clock, posedge
- `rstb`  in  1  asynchronous active-low reset
- `en_master`  in  1  global gate for issuing pulses to consumers
- `en_in`  in  [nParallel-1:0]  one-cycle enable pulse per lane from the sequencer
- `rdy_in`  in  [nParallel-1:0] x [ninputs-1:0] (unpacked)  `rdy_in[i][p]`: consumer i can accept a pulse on lane p this cycle
- `en_out`  out  [nParallel-1:0] x [ninputs-1:0] (unpacked)  `en_out[i][p]`: pulse delivered to consumer i, lane p
- `full`  out  [nParallel-1:0]  lane p has some consumer counter at `depth`
- `idle`  out  [nParallel-1:0]  all counters of lane p are zero
- `clr_overflow`  in  1  synchronous clear of `overflow`
- `overflow`  out  1  sticky; an `en_in` pulse was dropped

## Operation
- State is `cnt[p][i]`, `cw` bits, for each lane p and consumer i, plus the `overflow` register.
- `en_out[i][p] = (cnt[p][i] != 0) & rdy_in[i][p] & en_master`. This is combinational, matching the collect side.
- `full[p] = |{cnt[p][i] == depth}`. `idle[p] = &{cnt[p][i] == 0}`. Both are combinational from the registers.
- `accept[p] = en_in[p] & ~full[p]`.
- Counter update for each (p, i) on every clock:
  - `accept[p]` and not `en_out[i][p]`: cnt increments.
  - `en_out[i][p]` and not `accept[p]`: cnt decrements.
  - Both or neither: cnt holds. A consumer draining at full rate therefore never causes `full`.
- Overflow:
  - `en_in[p] & full[p]` drops the pulse for every consumer of lane p, so no partial fan-out occurs, and sets `overflow`.
  - `full` is evaluated on pre-update counter values. A simultaneous drain does not rescue the pulse.
  - `clr_overflow` clears `overflow`. If `clr_overflow` and a new drop occur in the same cycle, the set wins.
- Lanes are fully independent and consumers within a lane are independent.
- A deasserted `en_master` freezes delivery, but accepts continue up to `depth`.
- Counter arithmetic never wraps:
  - Increment happens only when cnt < `depth`, guaranteed by `~full`.
  - Decrement happens only when cnt > 0, guaranteed by the `en_out` term.

## Timing
- Reset, asynchronous on `rstb` low:
  - All cnt = 0 and `overflow` = 0.
  - Outputs go to `en_out` = all 0, `full` = 0, `idle` = all 1 immediately, without waiting for a clock.
  - Reset asserted mid-operation discards all outstanding pulses.
- Latency: `en_in[p]` accepted at edge t gives cnt = 1 after t. `en_out[i][p]` can assert in the cycle following t if `rdy_in[i][p]` and `en_master` are high. Minimum latency is 1 cycle, with no combinational path from `en_in` to `en_out`.
- Each `en_out` assertion is consumed at the following edge; one asserted cycle is one pulse. With ready held high, back-to-back pulses are delivered every cycle while cnt > 0.
- `full` and `idle` reflect register state. The sequencer samples `full` before pulsing `en_in`.
- Combinational paths: `rdy_in` and `en_master` to `en_out`. `en_out` and `full` feed the counter next-state logic; there is no loop.

## Test plan
- Reset, then `en_in[0]` pulsed once with all `rdy_in` and `en_master` high. Required: `en_out[i][0]` = 1 for all i in exactly the next cycle only; `idle[0]` returns to 1 one cycle after that; lanes 1–3 stay silent.
- `depth`=2, `rdy_in[3][1]` = 0, three `en_in[1]` pulses on consecutive cycles. Required:
  - first two pulses accepted; `full[1]` = 1 after the second;
  - third pulse dropped and `overflow` = 1;
  - consumers other than 3 receive exactly 2 pulses.
  - Raising `rdy_in[3][1]` then yields exactly 2 pulses to consumer 3.
- `depth`=2, cnt = 1 on all consumers, simultaneous `en_in[2]` and `en_out` on all consumers. Required: cnt stays 1, no overflow, `full[2]` stays 0.
- `en_master` = 0, two `en_in[0]` pulses. Required: no `en_out`, `full[0]` = 1. Then `en_master` = 1: two consecutive `en_out` cycles per consumer, then `idle[0]` = 1.
- Overflow set, then `clr_overflow` asserted in the same cycle as a new drop. Required: `overflow` stays 1. `clr_overflow` alone next cycle clears it to 0.
- `rstb` pulsed low mid-drain with cnt = 2 on lane 3. Required: `en_out` goes 0 and `idle[3]` goes 1 asynchronously, and no pulses are delivered after release.
